mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the CPU's single-port instruction/data memory between two requesters: the CPU control/datapath (fetch, LDA, STO) and a debug/program-loader port.
- Sequences each access through a fixed wait-state window, returns read data, and pulses a per-requester acknowledge.
- The CPU control FSM stalls its current phase until cpu_ack.
- Sits between the CPU core, the debug loader and the memory macro.

Parameters:
AWIDTH, 5, address width (32-word memory)
DWIDTH, 8, data width
WAIT_STATES, 1, extra cycles mem_rd/mem_wr are held beyond the first access cycle (0..7)
STARVE_LIMIT, 4, cycles debug may wait while losing arbitration before it is forced to win (1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; one clock; reset is asynchronous and active-high
cpu_req  in  1  CPU access request, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  AWIDTH  CPU address
cpu_wdata  in  DWIDTH  CPU write data
cpu_halt  in  1  CPU halted; debug gets priority
cpu_rdata  out  DWIDTH  CPU read data, registered
cpu_ack  out  1  one-cycle completion pulse
dbg_req  in  1  debug request, held until dbg_ack
dbg_we  in  1  debug write enable
dbg_addr  in  AWIDTH  debug address
dbg_wdata  in  DWIDTH  debug write data
dbg_rdata  out  DWIDTH  debug read data, registered
dbg_ack  out  1  one-cycle completion pulse
mem_addr  out  AWIDTH  memory address
mem_wdata  out  DWIDTH  memory write data
mem_rd  out  1  memory read strobe
mem_wr  out  1  memory write strobe
mem_rdata  in  DWIDTH  memory read data, valid while mem_rd is high
grant_dbg  out  1  1 while the debug access is in progress (ACCESS or DONE)

Behaviour:
- States: IDLE, ACCESS, DONE.
- Reset (asynchronous, any state): state = IDLE; all outputs 0, including cpu_rdata, dbg_rdata and the wait and starve counters. An in-flight access is abandoned and no ack is issued.
- IDLE, arbitration on each rising edge:
  - dbg wins if dbg_req && (cpu_halt || !cpu_req || starve_cnt == STARVE_LIMIT).
  - Otherwise cpu wins if cpu_req.
  - Otherwise stay in IDLE.
  - On a grant: latch the winner's addr/we/wdata into mem_addr/mem_wr-type/mem_wdata registers, load wait_cnt = WAIT_STATES, go to ACCESS.
- ACCESS:
  - mem_rd = !we_latched; mem_wr = we_latched.
  - mem_addr and mem_wdata are stable throughout.
  - Lasts WAIT_STATES+1 cycles, with wait_cnt decrementing each cycle.
  - On the edge where wait_cnt == 0: for a read, capture mem_rdata into the winner's rdata register; go to DONE.
- DONE:
  - Strobes low; winner's ack = 1 for exactly one cycle; next state IDLE.
  - Requests are not sampled in DONE. The requester may keep req high for a back-to-back access, arbitrated in the following IDLE cycle.
- Latency: req high at edge N in IDLE gives ack high during cycle N+WAIT_STATES+2. Throughput is one access per WAIT_STATES+3 cycles.
- starve_cnt (saturating at STARVE_LIMIT):
  - Increments on each IDLE arbitration edge where dbg_req = 1 and cpu wins.
  - Clears when dbg is granted.
  - Holds otherwise.
- Requester inputs may change after grant without effect; the arbiter uses the latched copies.
- rdata registers hold their last value until the next read by that requester. A write leaves them unchanged.
- grant_dbg is 1 from the grant edge through the DONE cycle.
- If cpu_halt rises mid-access, the current access completes normally; it only affects the next arbitration.

Test Plan:
1. WAIT_STATES=1, mem[5]=0x3C, cpu_req read addr 5 at edge 0 -> mem_rd high cycles 1-2 with mem_addr=5; cpu_ack cycle 3; cpu_rdata=0x3C.
2. cpu_halt=1, dbg write addr 0x1F data 0xA5 while cpu_req=1 -> dbg granted first; mem_wr high 2 cycles with mem_wdata=0xA5; dbg_ack pulse; then the CPU access runs; grant_dbg high only during the dbg access.
3. cpu_req and dbg_req both held high, cpu_halt=0, STARVE_LIMIT=4 -> 4 CPU accesses, then 1 dbg access (starve_cnt reached 4), then CPU again; starve_cnt reads 0 after the dbg grant.
4. Simultaneous cpu_req and dbg_req with starve_cnt=0, cpu_halt=0 -> CPU wins; dbg_ack stays 0 until the CPU's DONE cycle plus one arbitration.
5. Assert rst in the second ACCESS cycle of a CPU read -> mem_rd drops immediately (asynchronous); no cpu_ack; cpu_rdata=0; state IDLE after release.
6. WAIT_STATES=0, cpu_req held with reads of addr 0 then 1 -> acks every 3 cycles; each mem_rd pulse lasts 1 cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the single-port instruction/data memory between the CPU and the
//   debug/program-loader port. Each access runs a fixed wait-state window,
//   returns registered read data and pulses the winner's acknowledge.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module mem_port_arbiter #(
    parameter int AWIDTH       = 5,
    parameter int DWIDTH       = 8,
    parameter int WAIT_STATES  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [AWIDTH-1:0] cpu_addr,
    input  logic [DWIDTH-1:0] cpu_wdata,
    input  logic              cpu_halt,
    output logic [DWIDTH-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [AWIDTH-1:0] dbg_addr,
    input  logic [DWIDTH-1:0] dbg_wdata,
    output logic [DWIDTH-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              grant_dbg
);

    localparam logic [2:0] WAIT_INIT  = 3'(WAIT_STATES);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  wait_cnt;
    logic [3:0]  starve_cnt;
    logic        we_lat;     // latched write/read direction of the winner
    logic        owner_dbg;  // latched winner identity (1 = debug)
    logic        dbg_win;
    logic        cpu_win;
    logic        access_end;

    // Arbitration and next-state decode; requests are only sampled in IDLE
    always_comb begin
        dbg_win    = 1'b0;
        cpu_win    = 1'b0;
        access_end = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                dbg_win = dbg_req && (cpu_halt || !cpu_req || (starve_cnt == STARVE_MAX));
                cpu_win = cpu_req && !dbg_win;
                if (dbg_win || cpu_win) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                access_end = (wait_cnt == 3'd0);
                if (access_end) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset abandons any in-flight access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the winner's request and run the wait-state countdown
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            we_lat    <= 1'b0;
            owner_dbg <= 1'b0;
            wait_cnt  <= 3'd0;
        end else if (dbg_win || cpu_win) begin
            mem_addr  <= dbg_win ? dbg_addr  : cpu_addr;
            mem_wdata <= dbg_win ? dbg_wdata : cpu_wdata;
            we_lat    <= dbg_win ? dbg_we    : cpu_we;
            owner_dbg <= dbg_win;
            wait_cnt  <= WAIT_INIT;
        end else if ((state == ACCESS) && !access_end) begin
            wait_cnt  <= wait_cnt - 3'd1;
        end
    end

    // Capture read data into the winner's register on the last access edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rdata <= '0;
            dbg_rdata <= '0;
        end else if (access_end && !we_lat) begin
            if (owner_dbg) begin
                dbg_rdata <= mem_rdata;
            end else begin
                cpu_rdata <= mem_rdata;
            end
        end
    end

    // Count debug arbitration losses, saturating; a debug grant clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (dbg_win) begin
            starve_cnt <= 4'd0;
        end else if (cpu_win && dbg_req && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign mem_rd    = (state == ACCESS) && !we_lat;
    assign mem_wr    = (state == ACCESS) &&  we_lat;
    assign cpu_ack   = (state == DONE)   && !owner_dbg;
    assign dbg_ack   = (state == DONE)   &&  owner_dbg;
    assign grant_dbg = (state != IDLE)   &&  owner_dbg;

endmodule

`default_nettype wire
